vga_timing_generator: RTL

Raster timing source for the VGA display path. It produces the pixel position (`row`, `column`), the blanking qualifier (`blank_n`) and the active-low sync pulses for a 640×480 @ 60 Hz frame. These feed the colour generator and the board/next-field logic. A clock divider derives the pixel rate from the system clock. All outputs are registered and aligned to the same pixel.

---
 rtl/vga_timing_generator.sv | 115 +++++++++++
 1 files changed

// File: rtl/vga_timing_generator.sv
// Raster timing source for a 640x480@60 VGA frame.
// Pixel counters, sync/blank decodes and pixel-rate pulses, all registered.
module vga_timing_generator #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic [8:0] row,
  output logic [9:0] column,
  output logic       pixel_tick,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          adv;
  logic          h_wrap;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          blank_q, blank_d;
  logic [8:0]    row_q, row_d;
  logic [9:0]    col_q, col_d;
  logic          tick_q;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  logic          vis_v;

  always_comb begin
    adv    = (div_q == DIV_LAST);
    div_d  = adv ? '0 : div_q + DW'(1);
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + 10'd1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
    // decodes use the post-advance position
    hsync_d = !((h_d >= HS_START) && (h_d < HS_END));
    vsync_d = !((v_d >= VS_START) && (v_d < VS_END));
    vis_v   = (v_d < V_VIS);
    blank_d = (h_d < H_VIS) && vis_v;
    col_d   = blank_d ? h_d : '0;
    row_d   = vis_v ? v_d[8:0] : '0;
    ls_d    = (h_d == '0);
    fs_d    = ls_d && (v_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b1;
      row_q   <= '0;
      col_q   <= '0;
      tick_q  <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= adv;
      ls_q   <= adv && ls_d;
      fs_q   <= adv && fs_d;
      if (adv) begin
        h_q     <= h_d;
        v_q     <= v_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        blank_q <= blank_d;
        row_q   <= row_d;
        col_q   <= col_d;
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_q;
  assign row         = row_q;
  assign column      = col_q;
  assign pixel_tick  = tick_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule
